paddle_array: RTL and testbench

- Parametrised multi-player paddle controller for the Pong datapath; successor to the single fixed-step paddle.
- Each of NUM_PADDLES channels turns a 2-bit button pair into a clamped vertical position.
- Movement is symmetric, paced by a shared move tick, and accelerates while a button is held.
- Positions feed the renderer and collision logic.

---
 rtl/paddle_pkg.sv | 23 ++
 rtl/paddle_array_channel.sv | 120 ++++++++++++
 rtl/paddle_array.sv | 112 +++++++++++
 tb/tb_paddle_array.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle array and its per-channel controller.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } paddle_state_e;

    localparam logic [1:0] BTN_INC = 2'b01;
    localparam logic [1:0] BTN_DEC = 2'b10;

    // Bits needed to hold a step value in 0..dy_max
    function automatic int step_width(input int dy_max);
        return (dy_max < 1) ? 1 : $clog2(dy_max + 1);
    endfunction

    // Bits needed to hold a hold count in 0..accel_ticks
    function automatic int hold_width(input int accel_ticks);
        return (accel_ticks < 1) ? 1 : $clog2(accel_ticks + 1);
    endfunction

endpackage

// File: rtl/paddle_array_channel.sv
// One paddle channel: direction FSM, accelerating step, hold counter and
// saturating position clamp. Updates only on move_tick; recenter wins.
module paddle_channel
    import paddle_pkg::*;
#(
    parameter int YBIT_WIDTH      = 10,
    parameter int TOP_BOUNDARY    = 0,
    parameter int BOTTOM_BOUNDARY = 479,
    parameter int RESET_Y         = 240,
    parameter int DY_MIN          = 1,
    parameter int DY_MAX          = 4,
    parameter int ACCEL_TICKS     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                recenter,
    input  logic                move_tick,
    input  logic [1:0]          btn,
    output logic [YBIT_WIDTH:0] y_pos,
    output logic                at_top,
    output logic                at_bottom
);

    localparam int SW = step_width(DY_MAX);
    localparam int HW = hold_width(ACCEL_TICKS);
    localparam int YW = YBIT_WIDTH + 1;
    localparam int AW = YBIT_WIDTH + 2;

    localparam logic [SW-1:0] STEP_MIN = SW'(DY_MIN);
    localparam logic [SW-1:0] STEP_MAX = SW'(DY_MAX);
    localparam logic [HW-1:0] HOLD_LIM = HW'(ACCEL_TICKS);
    localparam logic [YW-1:0] Y_RESET  = YW'(RESET_Y);
    localparam logic [YW-1:0] Y_TOP    = YW'(TOP_BOUNDARY);
    localparam logic [YW-1:0] Y_BOT    = YW'(BOTTOM_BOUNDARY);
    localparam logic [AW-1:0] W_TOP    = AW'(TOP_BOUNDARY);
    localparam logic [AW-1:0] W_BOT    = AW'(BOTTOM_BOUNDARY);

    paddle_state_e state_q, state_d, dir;
    logic [SW-1:0] step_q, step_d, mv, base_step;
    logic [HW-1:0] hold_q, hold_d, hold_n;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] y_w, mv_w, sum_w;

    // State, step, hold and position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= STEP_MIN;
            hold_q  <= '0;
            y_q     <= Y_RESET;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
        end
    end

    // Direction decode, acceleration and clamped next position
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        hold_d    = hold_q;
        y_d       = y_q;
        dir       = IDLE;
        mv        = step_q;
        base_step = step_q;
        hold_n    = hold_q;
        y_w       = AW'(y_q);
        mv_w      = '0;
        sum_w     = '0;

        if (btn == BTN_INC)      dir = INC;
        else if (btn == BTN_DEC) dir = DEC;

        if (recenter) begin
            state_d = IDLE;
            step_d  = STEP_MIN;
            hold_d  = '0;
            y_d     = Y_RESET;
        end else if (move_tick) begin
            if (dir == IDLE) begin
                state_d = IDLE;
                step_d  = STEP_MIN;
                hold_d  = '0;
            end else begin
                if (dir == state_q) begin
                    mv        = step_q;
                    base_step = step_q;
                    hold_n    = hold_q + HW'(1);
                end else begin
                    mv        = STEP_MIN;
                    base_step = STEP_MIN;
                    hold_n    = HW'(1);
                end
                state_d = dir;
                if (hold_n == HOLD_LIM) begin
                    step_d = (base_step < STEP_MAX) ? base_step + SW'(1) : STEP_MAX;
                    hold_d = '0;
                end else begin
                    step_d = base_step;
                    hold_d = hold_n;
                end
                mv_w = AW'(mv);
                if (dir == INC) begin
                    sum_w = y_w + mv_w;
                    y_d   = (sum_w > W_BOT) ? Y_BOT : sum_w[YW-1:0];
                end else begin
                    sum_w = y_w - mv_w;
                    y_d   = (y_w < W_TOP + mv_w) ? Y_TOP : sum_w[YW-1:0];
                end
            end
        end
    end

    assign y_pos     = y_q;
    assign at_top    = (y_q == Y_TOP);
    assign at_bottom = (y_q == Y_BOT);

endmodule

// File: rtl/paddle_array.sv
// Multi-player paddle controller: shared move-tick generator, recenter fan-out
// and one paddle_channel per player. Optional button synchronizer/debouncer
// is enabled with macro PADDLE_DEBOUNCE_EN.
module paddle_array
    import paddle_pkg::*;
#(
    parameter int NUM_PADDLES     = 2,
    parameter int YBIT_WIDTH      = 10,
    parameter int TOP_BOUNDARY    = 0,
    parameter int BOTTOM_BOUNDARY = 479,
    parameter int RESET_Y         = 240,
    parameter int DY_MIN          = 1,
    parameter int DY_MAX          = 4,
    parameter int ACCEL_TICKS     = 2,
    parameter int TICK_DIV        = 833333
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  recenter,
    input  logic [NUM_PADDLES-1:0][1:0]           btn,
    output logic [NUM_PADDLES-1:0][YBIT_WIDTH:0]  yPos,
    output logic [NUM_PADDLES-1:0]                at_top,
    output logic [NUM_PADDLES-1:0]                at_bottom,
    output logic                                  move_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          tick_q;
    logic [NUM_PADDLES-1:0][1:0] btn_eff;

    // Next tick-counter value, wrapping at TICK_DIV-1
    always_comb begin
        cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    // Tick register is loaded with the decode of the next count so it is
    // high exactly while cnt_q == TICK_DIV-1, yet still a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            tick_q <= (cnt_nxt == CNT_LAST);
        end
    end

    assign move_tick = tick_q;

`ifdef PADDLE_DEBOUNCE_EN
    logic [NUM_PADDLES-1:0][1:0]      sync1_q, sync2_q, deb_q;
    logic [NUM_PADDLES-1:0][1:0][1:0] dcnt_q;

    // Two-flop synchronizer, then accept a new level after 4 differing ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (tick_q) begin
                for (int unsigned i = 0; i < NUM_PADDLES; i++) begin
                    for (int unsigned b = 0; b < 2; b++) begin
                        if (sync2_q[i][b] != deb_q[i][b]) begin
                            if (dcnt_q[i][b] == 2'd3) begin
                                deb_q[i][b]  <= sync2_q[i][b];
                                dcnt_q[i][b] <= '0;
                            end else begin
                                dcnt_q[i][b] <= dcnt_q[i][b] + 2'd1;
                            end
                        end else begin
                            dcnt_q[i][b] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign btn_eff = deb_q;
`else
    assign btn_eff = btn;
`endif

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
        paddle_channel #(
            .YBIT_WIDTH      (YBIT_WIDTH),
            .TOP_BOUNDARY    (TOP_BOUNDARY),
            .BOTTOM_BOUNDARY (BOTTOM_BOUNDARY),
            .RESET_Y         (RESET_Y),
            .DY_MIN          (DY_MIN),
            .DY_MAX          (DY_MAX),
            .ACCEL_TICKS     (ACCEL_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .recenter  (recenter),
            .move_tick (tick_q),
            .btn       (btn_eff[i]),
            .y_pos     (yPos[i]),
            .at_top    (at_top[i]),
            .at_bottom (at_bottom[i])
        );
    end

endmodule

// File: tb/tb_paddle_array.sv
// Scoreboard bench for paddle_array: stimulus pushes expected positions,
// a negedge monitor pops and compares on the cycle after each move tick.
module tb_paddle_array;

    localparam int N  = 2;
    localparam int YW = 10;

    logic clk = 1'b0;
    logic rst;
    logic recenter;
    logic [N-1:0][1:0]  btn, btn_b;
    logic [N-1:0][YW:0] ypos_a, ypos_b;
    logic [N-1:0]       top_a, bot_a, top_b, bot_b;
    logic               tick_a, tick_b;

    always #5 clk = ~clk;

    paddle_array #(.NUM_PADDLES(N), .YBIT_WIDTH(YW), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .recenter(recenter), .btn(btn),
        .yPos(ypos_a), .at_top(top_a), .at_bottom(bot_a), .move_tick(tick_a)
    );

    paddle_array #(.NUM_PADDLES(N), .YBIT_WIDTH(YW), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .recenter(recenter), .btn(btn_b),
        .yPos(ypos_b), .at_top(top_b), .at_bottom(bot_b), .move_tick(tick_b)
    );

    typedef struct {
        int y0;
        int y1;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    logic pend   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: compare registered outputs the cycle after a move tick
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (pend && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("ch0 yPos", int'(ypos_a[0]), mon_e.y0);
                check("ch1 yPos", int'(ypos_a[1]), mon_e.y1);
                check("ch0 top/bottom", int'({top_a[0], bot_a[0]}),
                      int'({mon_e.y0 == 0, mon_e.y0 == 479}));
                check("ch1 top/bottom", int'({top_a[1], bot_a[1]}),
                      int'({mon_e.y1 == 0, mon_e.y1 == 479}));
            end
            pend = tick_a;
        end
    end

    // One tick cycle of dut_a with its expected post-tick positions
    task automatic cyc(input logic [1:0] b0, input logic [1:0] b1, input logic rc,
                       input int e0, input int e1);
        exp_t e;
        btn[0]   = b0;
        btn[1]   = b1;
        recenter = rc;
        e.y0 = e0;
        e.y1 = e1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int acc[8];
        int rev0[6];
        int rev1[6];
        int y0;
        int y1;
        int exp_y;
        acc  = '{241, 242, 244, 246, 249, 252, 256, 260};
        rev0 = '{259, 258, 256, 254, 254, 253};
        rev1 = '{239, 238, 236, 234, 234, 233};

        rst = 1'b1; recenter = 1'b0; btn = '0; btn_b = '0;
        #21 rst = 1'b0;
        @(posedge clk); #1;
        check("tick constant after release", int'(tick_a), 1);

        // Move, then reset asynchronously in the middle of a moving cycle
        cyc(2'b01, 2'b00, 1'b0, 241, 240);
        cyc(2'b01, 2'b00, 1'b0, 242, 240);
        cyc(2'b01, 2'b00, 1'b0, 244, 240);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("reset ch0 yPos", int'(ypos_a[0]), 240);
        check("reset ch1 yPos", int'(ypos_a[1]), 240);
        check("reset at_top", int'(top_a), 0);
        check("reset at_bottom", int'(bot_a), 0);
        check("reset move_tick", int'(tick_a), 0);
        btn = '0;
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Acceleration on ch0, ch1 idle
        for (int k = 0; k < 8; k++) cyc(2'b01, 2'b00, 1'b0, acc[k], 240);

        // Reversal on ch0, independent decrease/idle/decrease on ch1
        for (int k = 0; k < 6; k++)
            cyc((k == 4) ? 2'b11 : 2'b10, (k == 4) ? 2'b11 : 2'b10, 1'b0, rev0[k], rev1[k]);

        // Recenter with buttons held
        cyc(2'b01, 2'b10, 1'b1, 240, 240);

        // Bottom clamp on ch0, top clamp on ch1
        y0 = 240; y1 = 240;
        for (int k = 0; k < 66; k++) begin
            if (k < 8) begin
                y0 = acc[k];
                y1 = 480 - acc[k];
            end else begin
                y0 = (y0 + 4 > 479) ? 479 : y0 + 4;
                y1 = (y1 < 4) ? 0 : y1 - 4;
            end
            cyc(2'b01, 2'b10, 1'b0, y0, y1);
        end

        // ch0 down to the top with a non-multiple remainder
        for (int k = 0; k < 125; k++) begin
            if (k < 8) y0 = 479 - (acc[k] - 240);
            else       y0 = (y0 < 4) ? 0 : y0 - 4;
            cyc(2'b10, 2'b10, 1'b0, y0, 0);
        end

        // Recenter, ramp ch0 to 300, then recenter against a held tick
        cyc(2'b10, 2'b10, 1'b1, 240, 240);
        for (int k = 0; k < 18; k++) begin
            y0 = (k < 8) ? acc[k] : y0 + 4;
            cyc(2'b01, 2'b00, 1'b0, y0, 240);
        end
        cyc(2'b01, 2'b00, 1'b1, 240, 240);
        cyc(2'b01, 2'b00, 1'b0, 241, 240);
        cyc(2'b01, 2'b00, 1'b0, 242, 240);
        cyc(2'b00, 2'b00, 1'b0, 242, 240);
        btn = '0;
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 0);

        // TICK_DIV=4 instance from a fresh reset
        rst = 1'b1;
        btn_b[0] = 2'b01;
        btn_b[1] = 2'b00;
        @(negedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            check($sformatf("div4 move_tick c%0d", c), int'(tick_b),
                  (c == 3 || c == 7 || c == 11) ? 1 : 0);
            if (c <= 3)       exp_y = 240;
            else if (c <= 7)  exp_y = 241;
            else if (c <= 11) exp_y = 242;
            else              exp_y = 244;
            check($sformatf("div4 ch0 yPos c%0d", c), int'(ypos_b[0]), exp_y);
            check($sformatf("div4 ch1 yPos c%0d", c), int'(ypos_b[1]), 240);
            if (c == 12) check("div4 top/bottom", int'({top_b, bot_b}), 0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
